// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel counters, sync/DE generation and line/frame ticks.
// Ports: clk, rst (async, active-high), pix_ce in; x, y (undelayed counters),
//   hsync, vsync, de (delayed OUT_LATENCY clks), line_start, frame_start,
//   vblank (undelayed), frame_cnt out.
// Optional macro VGA_FRAME_CNT_EN: enables the 16-bit frame counter;
//   when undefined frame_cnt is tied to zero.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int OUT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic        vblank,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // {hsync, vsync, de} with every signal deasserted
  localparam logic [2:0] IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  if (OUT_LATENCY < 0 || OUT_LATENCY > 4 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (pix_ce) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      end
      // ticks flag the step into (0,*) / (0,0), never the reset state
      line_d  = h_wrap;
      frame_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  logic       hs_raw, vs_raw, de_raw;
  logic [2:0] raw;
  logic [2:0] dly_out;

  always_comb begin
    hs_raw = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_raw = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
    de_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    raw    = {hs_raw, vs_raw, de_raw};
  end

  // Delay line runs every clk so RGB registered downstream stays aligned
  // regardless of pix_ce.
  if (OUT_LATENCY == 0) begin : g_pass
    // (0,0) is a visible pixel, so de is masked while reset is held
    assign dly_out = {raw[2:1], raw[0] & ~rst};
  end else begin : g_dly
    logic [2:0] dly_q [OUT_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < OUT_LATENCY; i++) begin
          dly_q[i] <= IDLE;
        end
      end else begin
        dly_q[0] <= raw;
        for (int i = 1; i < OUT_LATENCY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign dly_out = dly_q[OUT_LATENCY-1];
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q + {15'd0, frame_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign hsync       = dly_out[2];
  assign vsync       = dly_out[1];
  assign de          = dly_out[0];
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign vblank      = (v_cnt_q >= V_ACT);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Reduced-timing instance checked every clk; default VGA instance for line timing.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst;
  logic pix_ce;

  always #5 clk = ~clk;

  logic [9:0]  sx, sy, bx, by;
  logic        shs, svs, sde, sls, sfs, svb;
  logic        bhs, bvs, bde, bls, bfs, bvb;
  logic [15:0] sfc, bfc;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .OUT_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .x(sx), .y(sy), .hsync(shs), .vsync(svs), .de(sde),
    .line_start(sls), .frame_start(sfs), .vblank(svb),
    .frame_cnt(sfc)
  );

  vga_timing_gen u_big (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .x(bx), .y(by), .hsync(bhs), .vsync(bvs), .de(bde),
    .line_start(bls), .frame_start(bfs), .vblank(bvb),
    .frame_cnt(bfc)
  );

  int checks = 0;
  int errors = 0;

  typedef logic [41:0] vec_t;
  vec_t sb_q[$];

  int   n;
  int   m_fc;
  logic m_hs, m_vs, m_de;
  int   cyc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hs_of(input int h);
    return !(h >= HA + HF && h < HA + HF + HS);
  endfunction

  function automatic logic vs_of(input int v);
    return !(v >= VA + VF && v < VA + VF + VS);
  endfunction

  task automatic model_reset();
    n    = 0;
    m_fc = 0;
    m_hs = 1'b1;
    m_vs = 1'b1;
    m_de = 1'b0;
    cyc  = 0;
  endtask

  task automatic step(input logic ce);
    int   h, v;
    logic ls, fs;
    vec_t e;
    pix_ce = ce;
    @(posedge clk);
    h    = n % HT;
    v    = (n / HT) % VT;
    m_hs = hs_of(h);
    m_vs = vs_of(v);
    m_de = (h < HA) && (v < VA);
    ls   = 1'b0;
    fs   = 1'b0;
    if (ce) begin
      n++;
      h  = n % HT;
      v  = (n / HT) % VT;
      ls = (h == 0);
      fs = ls && (v == 0);
    end
`ifdef VGA_FRAME_CNT_EN
    if (fs) m_fc = (m_fc + 1) % 65536;
`endif
    sb_q.push_back({10'(h), 10'(v), m_hs, m_vs, m_de, ls, fs,
                    (v >= VA), 16'(m_fc)});
    @(negedge clk);
    e = sb_q.pop_front();
    chk("cycle", {sx, sy, shs, svs, sde, sls, sfs, svb, sfc}, e);
    cyc++;
  endtask

  logic mon_en = 1'b0;
  logic prev_bhs = 1'b1;
  int   mc = 0, x656_c = -1, fall_c = -1, rise_c = -1;
  int   bls1 = -1, bls2 = -1, bde_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bx == 10'd656 && x656_c < 0) x656_c = mc;
      if (prev_bhs && !bhs && fall_c < 0) fall_c = mc;
      if (!prev_bhs && bhs && fall_c >= 0 && rise_c < 0) rise_c = mc;
      if (bls) begin
        if (bls1 < 0) bls1 = mc;
        else if (bls2 < 0) bls2 = mc;
      end
      if (bde && mc < 800) bde_cnt++;
      prev_bhs = bhs;
      mc++;
    end
  end

  initial begin
    int   fs1, fs2, fs_cnt, vs_low;
    int   ls1, ls2, f3, r3, k, guard;
    logic p_hs;

    rst    = 1'b1;
    pix_ce = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x", sx, 0);
    chk("rst_y", sy, 0);
    chk("rst_hsync", shs, 1);
    chk("rst_vsync", svs, 1);
    chk("rst_de", sde, 0);
    chk("rst_line", sls, 0);
    chk("rst_frame", sfs, 0);
    chk("rst_vblank", svb, 0);
    chk("rst_fcnt", sfc, 0);
    chk("rst_big", {bx, by, bhs, bvs, bde, bls, bfs, bvb, bfc},
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});

    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    model_reset();

    fs1 = -1; fs2 = -1; fs_cnt = 0; vs_low = 0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b1);
      if (sfs) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
      if (!svs) vs_low++;
    end
    mon_en = 1'b0;
    chk("frame_count", fs_cnt, 4);
    chk("frame_period", fs2 - fs1, FT);
    chk("vsync_low_clks", vs_low, 4 * VS * HT);
    chk("big_hs_fall_vs_x656", fall_c - x656_c, 1);
    chk("big_hs_low_clks", rise_c - fall_c, 96);
    chk("big_line_period", bls2 - bls1, 800);
    chk("big_de_per_line", bde_cnt, 640);

    ls1 = -1; ls2 = -1; f3 = -1; r3 = -1;
    p_hs = shs;
    for (int i = 0; i < 400; i++) begin
      step((i % 4) == 0);
      if (sls) begin
        if (ls1 < 0) ls1 = i;
        else if (ls2 < 0) ls2 = i;
      end
      if (p_hs && !shs && f3 < 0) f3 = i;
      if (!p_hs && shs && f3 >= 0 && r3 < 0) r3 = i;
      p_hs = shs;
    end
    chk("ce4_line_period", ls2 - ls1, 4 * HT);
    chk("ce4_hs_low_clks", r3 - f3, 4 * HS);

    guard = 0;
    while (!((n % HT) == 10 && ((n / HT) % VT) == 5) && guard < 2 * FT) begin
      step(1'b1);
      guard++;
    end
    chk("mid_x", sx, 10);
    chk("mid_y", sy, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_x", sx, 0);
    chk("arst_y", sy, 0);
    chk("arst_de", sde, 0);
    chk("arst_hsync", shs, 1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (k = 1; k <= 2 * FT; k++) begin
      step(1'b1);
      if (sfs) break;
    end
    chk("frame_after_rst", k, FT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
